demux_1xn_tdm: RTL and testbench
================================

Name: demux_1xN_tdm

Overview:
Receive end of the N-to-1 multiplexer path. The mux serializes an N-bit word by sweeping its select from 0 to N-1. This block takes that 1-bit stream plus the slot index and routes each bit to its own output (registered 1xN demux). It also reassembles complete in-order sweeps into an N-bit frame word, with a completion pulse, a sequence-error flag and a frame counter.

Parameters:
N, 8, number of slots / output width; 1 <= N <= 2**R
R, 3, select width; slot index range 0..2**R-1
CW, 8, frame counter width

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst_n  input  1  synchronous active-low reset, sampled on rising clk
din  input  1  serial data bit (mux output y)
sel  input  R  slot index accompanying din (mux select s)
valid  input  1  din/sel qualify this cycle
y  output  N  per-slot registered demux outputs
word  output  N  last completely assembled frame
word_valid  output  1  one-cycle pulse when word updates
err  output  1  one-cycle pulse on sequence violation
frame_cnt  output  CW  completed-frame count, wraps

Behaviour:
- Reset (rst_n=0 at a rising edge), regardless of valid: y=0, word=0, word_valid=0, err=0, frame_cnt=0, internal shadow=0, exp_slot=0, state=IDLE.
- Reset mid-frame discards the partial frame. word is also cleared.
- Demux path: on a rising edge with valid=1 and sel<N, y[sel] takes din. All other y bits hold.
  - Latency is 1 cycle.
  - valid=0 changes nothing.
  - sel>=N never writes y.
- FSM states: IDLE, COLLECT. exp_slot is an R-bit register.
- IDLE:
  - valid=1, sel=0: shadow[0]<=din, exp_slot<=1, go to COLLECT.
  - If N=1, the frame completes immediately, as for the last slot below.
  - valid=1, sel!=0: err pulses next cycle; stay in IDLE.
- COLLECT:
  - valid=1, sel==exp_slot: shadow[sel]<=din, exp_slot<=exp_slot+1.
  - If sel==N-1 this completes the frame:
    - word <= shadow with bit N-1 = din;
    - word_valid=1 for the next cycle only;
    - frame_cnt+1, wrapping 2**CW-1 -> 0;
    - exp_slot<=0, go to IDLE.
  - valid=1, sel!=exp_slot: err pulses next cycle.
    - If sel==0: restart. shadow[0]<=din, exp_slot<=1, stay in COLLECT.
    - Otherwise: exp_slot<=0, go to IDLE.
    - word and frame_cnt are unchanged in either case.
  - valid=0: hold all state. Gaps of any length between slots are legal.
- sel>=N is always a sequence violation and is handled as above.
- word holds its value between completions. word_valid and err are never both 1 on the same cycle.
- Back-to-back frames: sel=0 on the cycle right after a completion is accepted normally (state is already IDLE).
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles while valid=1, sel=3, din=1 -> y=0, word=0, word_valid=0, err=0, frame_cnt=0.
2. Clean sweep: valid=1, sel=0..7 on consecutive cycles, din=8'hA6[sel] -> y=8'hA6 after the last edge. word_valid pulses exactly one cycle after sel=7, word=8'hA6, frame_cnt=1, err never asserted.
3. Gapped sweep: same as scenario 2 with valid=0 for 3 cycles between every slot, data 8'h5B -> single word_valid pulse, word=8'h5B, frame_cnt increments by exactly 1.
4. Out-of-order: sel 0,1,2 then sel=5 -> err pulses one cycle after sel=5, no word_valid, word keeps its prior value. Then a clean sweep of 8'h3C -> word=8'h3C, frame_cnt increments.
5. Restart and reset mid-frame:
   - sel 0,1,2,0,1..7 with data 8'hF0 on the second sweep -> one err pulse at the second sel=0, then word=8'hF0.
   - Separately, assert rst_n=0 after slot 4 -> word=0; a following clean sweep completes normally.
6. Wrap and boundaries:
   - 256 back-to-back clean sweeps with CW=8 -> frame_cnt goes 255 -> 0, word_valid pulses 256 times.
   - With N=6, R=3: sel=6 during COLLECT -> err pulses, y unchanged.

Source files
------------

// File: rtl/demux_1xn_tdm.sv
// Receive side of the TDM mux path: registered 1xN demux of a serial bit stream,
// plus in-order sweep reassembly into frame words with error pulse and frame counter.
module demux_1xn_tdm #(
  parameter int unsigned N  = 8,
  parameter int unsigned R  = 3,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic [R-1:0]  sel,
  input  logic          valid,
  output logic [N-1:0]  y,
  output logic [N-1:0]  word,
  output logic          word_valid,
  output logic          err,
  output logic [CW-1:0] frame_cnt
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [R-1:0]  exp_slot, exp_slot_nxt;
  logic [N-1:0]  shadow, shadow_nxt;
  logic [N-1:0]  y_nxt, word_nxt;
  logic          word_valid_nxt, err_nxt;
  logic [CW-1:0] frame_cnt_nxt;

  logic [N-1:0]  slot_hot;
  logic [N-1:0]  shadow_wr;
  logic          last_slot;

  // One-hot decode of sel; stays all-zero for sel >= N so out-of-range slots never write
  always_comb begin
    slot_hot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == R'(i)) slot_hot[i] = 1'b1;
    end
    shadow_wr = (shadow & ~slot_hot) | (slot_hot & {N{din}});
    last_slot = (sel == R'(N - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      exp_slot   <= '0;
      shadow     <= '0;
      y          <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      err        <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      exp_slot   <= exp_slot_nxt;
      shadow     <= shadow_nxt;
      y          <= y_nxt;
      word       <= word_nxt;
      word_valid <= word_valid_nxt;
      err        <= err_nxt;
      frame_cnt  <= frame_cnt_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt      = state;
    exp_slot_nxt   = exp_slot;
    shadow_nxt     = shadow;
    y_nxt          = y;
    word_nxt       = word;
    word_valid_nxt = 1'b0;
    err_nxt        = 1'b0;
    frame_cnt_nxt  = frame_cnt;

    if (valid) begin
      y_nxt = (y & ~slot_hot) | (slot_hot & {N{din}});

      unique case (state)
        IDLE: begin
          if (sel == '0) begin
            shadow_nxt = shadow_wr;
            if (N == 1) begin
              word_nxt       = shadow_wr;
              word_valid_nxt = 1'b1;
              frame_cnt_nxt  = frame_cnt + CW'(1);
              exp_slot_nxt   = '0;
            end else begin
              exp_slot_nxt = R'(1);
              state_nxt    = COLLECT;
            end
          end else begin
            err_nxt = 1'b1;
          end
        end

        COLLECT: begin
          if (sel == exp_slot) begin
            shadow_nxt = shadow_wr;
            if (last_slot) begin
              word_nxt       = shadow_wr;
              word_valid_nxt = 1'b1;
              frame_cnt_nxt  = frame_cnt + CW'(1);
              exp_slot_nxt   = '0;
              state_nxt      = IDLE;
            end else begin
              exp_slot_nxt = exp_slot + R'(1);
            end
          end else begin
            err_nxt = 1'b1;
            // A fresh slot 0 restarts the frame instead of dropping back to IDLE
            if (sel == '0) begin
              shadow_nxt   = shadow_wr;
              exp_slot_nxt = R'(1);
            end else begin
              exp_slot_nxt = '0;
              state_nxt    = IDLE;
            end
          end
        end

        default: begin
          state_nxt    = IDLE;
          exp_slot_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_1xn_tdm.sv
// Scoreboard bench for demux_1xn_tdm: drivers queue expected frames and error pulses,
// a negedge monitor retires them as the DUT presents word_valid / err.
module tb_demux_1xn_tdm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din, valid;
  logic [2:0] sel;
  logic [7:0] y, word, frame_cnt;
  logic       word_valid, err;

  logic       din6, valid6;
  logic [2:0] sel6;
  logic [5:0] y6, word6;
  logic       word_valid6, err6;
  logic [7:0] frame_cnt6;

  int checks = 0;
  int errors = 0;
  int err_exp = 0;
  int wv_seen = 0;
  logic [15:0] frame_q[$];
  logic [7:0]  exp_cnt;
  logic [7:0]  last_word;

  always #5 clk = ~clk;

  demux_1xn_tdm #(.N(8), .R(3), .CW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .valid(valid),
    .y(y), .word(word), .word_valid(word_valid), .err(err), .frame_cnt(frame_cnt)
  );

  demux_1xn_tdm #(.N(6), .R(3), .CW(8)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .din(din6), .sel(sel6), .valid(valid6),
    .y(y6), .word(word6), .word_valid(word_valid6), .err(err6), .frame_cnt(frame_cnt6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: retire expected frames / error pulses as the DUT shows them
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (word_valid) begin
        wv_seen++;
        if (frame_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word_valid: got word %0h cnt %0d expected no pulse", word, frame_cnt);
        end else begin
          logic [15:0] e;
          e = frame_q.pop_front();
          chk("frame_word", 32'(word), 32'(e[15:8]));
          chk("frame_cnt", 32'(frame_cnt), 32'(e[7:0]));
        end
      end
      if (err) begin
        checks++;
        if (err_exp == 0) begin
          errors++;
          $display("FAIL unexpected_err: got err=1 expected 0");
        end else begin
          err_exp--;
        end
      end
      if (word_valid && err) begin
        checks++; errors++;
        $display("FAIL wv_err_overlap: got both 1 expected exclusive");
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] s, input logic d);
    sel = s; din = d; valid = 1'b1;
    tick(1);
    valid = 1'b0;
  endtask

  // Full in-order sweep; err_first marks slot 0 as a restart of a partial frame
  task automatic sweep(input logic [7:0] data, input int gap, input bit err_first);
    logic [2:0] s;
    exp_cnt = exp_cnt + 8'd1;
    frame_q.push_back({data, exp_cnt});
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      if (i == 0 && err_first) err_exp++;
      send(s, data[i]);
      if (gap > 0 && i < 7) tick(gap);
    end
    last_word = data;
  endtask

  task automatic send6(input logic [2:0] s, input logic d);
    sel6 = s; din6 = d; valid6 = 1'b1;
    tick(1);
    valid6 = 1'b0;
  endtask

  initial begin
    logic [7:0] dat;
    logic [5:0] y6_before;
    int         wv_base;
    rst_n = 1'b0; din = 1'b1; sel = 3'd3; valid = 1'b1;
    din6 = 1'b0; sel6 = '0; valid6 = 1'b0;
    exp_cnt = 8'd0; last_word = 8'd0;

    // 1: reset dominates valid
    tick(2);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_word", 32'(word), 32'h0);
    chk("rst_wv", 32'(word_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_cnt", 32'(frame_cnt), 32'h0);
    rst_n = 1'b1; valid = 1'b0;
    tick(1);

    // 2: clean back-to-back sweep
    sweep(8'hA6, 0, 1'b0);
    chk("sweep_y", 32'(y), 32'hA6);
    chk("sweep_wv_now", 32'(word_valid), 32'h1);
    tick(1);
    chk("sweep_wv_single", 32'(word_valid), 32'h0);

    // 3: gapped sweep
    tick(2);
    sweep(8'h5B, 3, 1'b0);
    chk("gap_y", 32'(y), 32'h5B);
    tick(2);

    // 4: out-of-order slot aborts the frame, word holds
    send(3'd0, 1'b0); send(3'd1, 1'b1); send(3'd2, 1'b0);
    err_exp++;
    send(3'd5, 1'b1);
    chk("ooo_err", 32'(err), 32'h1);
    tick(1);
    chk("ooo_word_hold", 32'(word), 32'(last_word));
    chk("ooo_cnt_hold", 32'(frame_cnt), 32'(exp_cnt));
    sweep(8'h3C, 0, 1'b0);
    tick(2);

    // 5a: restart at slot 0 mid-frame
    send(3'd0, 1'b1); send(3'd1, 1'b1); send(3'd2, 1'b1);
    sweep(8'hF0, 0, 1'b1);
    tick(2);
    chk("restart_word", 32'(word), 32'hF0);

    // 5b: reset after slot 4 discards the partial frame and clears word
    for (int i = 0; i < 5; i++) send(3'(i), 1'b1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    exp_cnt = 8'd0; last_word = 8'd0;
    chk("midrst_word", 32'(word), 32'h0);
    chk("midrst_cnt", 32'(frame_cnt), 32'h0);
    sweep(8'h81, 0, 1'b0);
    tick(1);
    chk("midrst_sweep_cnt", 32'(frame_cnt), 32'h1);

    // 6a: 256 back-to-back sweeps wrap the counter
    wv_base = wv_seen;
    for (int k = 0; k < 256; k++) begin
      dat = 8'(k * 37 + 11);
      sweep(dat, 0, 1'b0);
    end
    tick(2);
    chk("wrap_pulses", 32'(wv_seen - wv_base), 32'd256);
    chk("wrap_cnt", 32'(frame_cnt), 32'h1);

    // 6b: N=6, slot 6 is out of range
    send6(3'd0, 1'b1); send6(3'd1, 1'b1);
    y6_before = y6;
    send6(3'd6, 1'b0);
    chk("n6_err", 32'(err6), 32'h1);
    chk("n6_y_hold", 32'(y6), 32'(y6_before));
    tick(1);
    chk("n6_err_single", 32'(err6), 32'h0);
    send6(3'd7, 1'b1);
    chk("n6_idle_err", 32'(err6), 32'h1);
    chk("n6_y7_hold", 32'(y6), 32'(y6_before));
    for (int i = 0; i < 6; i++) send6(3'(i), (6'h2D >> i) & 6'h1);
    chk("n6_wv", 32'(word_valid6), 32'h1);
    chk("n6_word", 32'(word6), 32'h2D);
    chk("n6_cnt", 32'(frame_cnt6), 32'h1);

    tick(3);
    chk("queue_drained", 32'(frame_q.size()), 32'h0);
    chk("err_drained", 32'(err_exp), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
